// File: rtl/vpu_cfg_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_cfg_dispatch_pkg
//  Description : Shared VPU types used by the vector-config dispatch path:
//                CSR/config op encoding, the config micro-op layout, the
//                dispatch FSM state encoding and the drain-classification
//                helper (also reused by the ISSUE stage).
//  Revision    : 1.0 - initial release
// ============================================================================
package vpu_cfg_dispatch_pkg;

    localparam int VPU_XLEN = 32;

    typedef enum logic [3:0] {
        CFG_VSETVLI      = 4'd0,
        CFG_VSETIVLI     = 4'd1,
        CFG_VSETVL       = 4'd2,
        CFG_VLENB_READ   = 4'd3,
        CFG_VTYPE_READ   = 4'd4,
        CFG_VL_READ      = 4'd5,
        CFG_VSTART_WRITE = 4'd6,
        CFG_VXRM_WRITE   = 4'd7,
        CFG_VXSAT_WRITE  = 4'd8,
        CFG_VCSR_WRITE   = 4'd9
    } CFG_CSR_OP_e;

    typedef struct packed {
        CFG_CSR_OP_e csr_op;
    } VPU_CFG_MODE_t;

    typedef struct packed {
        VPU_CFG_MODE_t cfg;
    } VPU_MODE_t;

    typedef struct packed {
        logic [VPU_XLEN-1:0] xval;
    } VPU_RS1_t;

    typedef struct packed {
        VPU_MODE_t  mode;
        logic [7:0] vtype;
        logic       keep_vl;
        logic [7:0] vlmax;
        VPU_RS1_t   rs1;
    } VPU_uOP_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        WB    = 2'd3
    } CFG_DISP_STATE_e;

    // Pure reads of vlenb/vtype/vl do not depend on in-flight vector work;
    // everything else modifies vector CSR state and must wait for drain.
    function automatic logic cfg_needs_drain(input CFG_CSR_OP_e csr_op);
        case (csr_op)
            CFG_VLENB_READ,
            CFG_VTYPE_READ,
            CFG_VL_READ:    return 1'b0;
            default:        return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_cfg_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_cfg_dispatch_if
//  Description : Bundle of the ISSUE uop channel, the CSR-unit strobe/read
//                channel and the COMMIT writeback channel of the config
//                dispatcher. Signal suffixes are from the dispatcher's view.
//                modport slave  : the dispatcher itself
//                modport master : its environment (ISSUE, CSR unit, COMMIT)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vpu_cfg_dispatch_if
    import vpu_cfg_dispatch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RD_BITS = 5
);
    logic               uop_valid_i;
    logic               uop_ready_o;
    VPU_uOP_t           uop_i;
    logic [RD_BITS-1:0] uop_rd_i;
    logic               uop_rd_we_i;
    logic               flush_i;
    logic               vec_inflight_i;
    logic               vec_issue_block_o;
    logic               VCFG_valid_o;
    VPU_uOP_t           VCFG_entry_o;
    logic               VCFG_read_valid_i;
    logic [XLEN-1:0]    VCFG_read_data_i;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [RD_BITS-1:0] wb_rd_o;
    logic [XLEN-1:0]    wb_data_o;

    modport slave (
        input  uop_valid_i, uop_i, uop_rd_i, uop_rd_we_i, flush_i,
               vec_inflight_i, VCFG_read_valid_i, VCFG_read_data_i, wb_ready_i,
        output uop_ready_o, vec_issue_block_o, VCFG_valid_o, VCFG_entry_o,
               wb_valid_o, wb_rd_o, wb_data_o
    );

    modport master (
        output uop_valid_i, uop_i, uop_rd_i, uop_rd_we_i, flush_i,
               vec_inflight_i, VCFG_read_valid_i, VCFG_read_data_i, wb_ready_i,
        input  uop_ready_o, vec_issue_block_o, VCFG_valid_o, VCFG_entry_o,
               wb_valid_o, wb_rd_o, wb_data_o
    );
endinterface
`default_nettype wire

// File: rtl/vpu_cfg_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_cfg_dispatch
//  Description : Initiator side of the vector-config channel. Takes one
//                config/CSR uop at a time from ISSUE, waits for the vector
//                pipeline to drain when the op modifies CSR state, strobes
//                the CSR unit for one cycle, captures its same-cycle read
//                response and hands it to COMMIT over valid/ready.
//  Ports       : clk_i   - clock, rising edge
//                rst_ni  - asynchronous active-low reset
//                bus     - vpu_cfg_dispatch_if.slave (uop in, CSR strobe,
//                          writeback out, issue-block, flush, inflight)
//  Options     : VPU_CFG_DISPATCH_BYPASS_EN - non-draining ops with rd_we
//                strobe the CSR unit combinationally in IDLE and go straight
//                to WB. Undefined by default.
//  Revision    : 1.0 - initial release
// ============================================================================
module vpu_cfg_dispatch
    import vpu_cfg_dispatch_pkg::*;
#(
    parameter int XLEN    = VPU_XLEN,
    parameter int RD_BITS = 5
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    vpu_cfg_dispatch_if.slave  bus
);

    CFG_DISP_STATE_e    r_state;
    VPU_uOP_t           r_uop;
    logic [RD_BITS-1:0] r_rd;
    logic               r_rd_we;
    logic [XLEN-1:0]    r_data;
    logic               r_vcfg_valid;
    logic               r_wb_valid;
    logic               r_block;

    logic               w_ready;
    logic               w_take;
    logic               w_drain;
    logic               w_bypass;
    logic [XLEN-1:0]    w_rsp_data;

    // Ready is forced low while reset is held so every output reads 0 then.
    assign w_ready    = (r_state == IDLE) && rst_ni;
    // A flush coinciding with an offered uop drops that uop.
    assign w_take     = bus.uop_valid_i && w_ready && !bus.flush_i;
    assign w_drain    = cfg_needs_drain(bus.uop_i.mode.cfg.csr_op);
    assign w_rsp_data = bus.VCFG_read_valid_i ? bus.VCFG_read_data_i : '0;

`ifdef VPU_CFG_DISPATCH_BYPASS_EN
    assign w_bypass   = w_take && !w_drain && bus.uop_rd_we_i;
`else
    assign w_bypass   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_uop        <= '0;
            r_rd         <= '0;
            r_rd_we      <= 1'b0;
            r_data       <= '0;
            r_vcfg_valid <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_block      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_uop   <= bus.uop_i;
                        r_rd    <= bus.uop_rd_i;
                        r_rd_we <= bus.uop_rd_we_i;
                        if (w_bypass) begin
                            r_data     <= w_rsp_data;
                            r_wb_valid <= 1'b1;
                            r_state    <= WB;
                        end else if (w_drain && bus.vec_inflight_i) begin
                            r_block <= 1'b1;
                            r_state <= DRAIN;
                        end else begin
                            // Block is raised for non-drained CSR writers too
                            // so ISSUE cannot slip a vector op past the strobe.
                            r_block      <= w_drain;
                            r_vcfg_valid <= 1'b1;
                            r_state      <= ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.flush_i) begin
                        r_block <= 1'b0;
                        r_state <= IDLE;
                    end else if (!bus.vec_inflight_i) begin
                        r_vcfg_valid <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // CSR state is committed by the strobe; flush has no effect here.
                    r_vcfg_valid <= 1'b0;
                    r_block      <= 1'b0;
                    r_data       <= w_rsp_data;
                    if (r_rd_we) begin
                        r_wb_valid <= 1'b1;
                        r_state    <= WB;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                WB: begin
                    if (bus.wb_ready_i) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.uop_ready_o       = w_ready;
    assign bus.vec_issue_block_o = r_block;
    assign bus.VCFG_valid_o      = r_vcfg_valid | w_bypass;
    assign bus.VCFG_entry_o      = w_bypass ? bus.uop_i : r_uop;
    assign bus.wb_valid_o        = r_wb_valid;
    assign bus.wb_rd_o           = r_rd;
    assign bus.wb_data_o         = r_data;

endmodule
`default_nettype wire

// File: tb/tb_vpu_cfg_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vpu_cfg_dispatch
//  Description : Self-checking bench for vpu_cfg_dispatch (default build,
//                VPU_CFG_DISPATCH_BYPASS_EN undefined). Directed ops push
//                expected CSR strobes and writebacks into queues; monitors
//                pop and compare whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vpu_cfg_dispatch;
    import vpu_cfg_dispatch_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] xv;
    } vexp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wexp_t;

    logic        clk;
    logic        rst_ni;
    logic        resp_en;
    logic [31:0] resp_data;
    int          checks;
    int          failures;
    vexp_t       vq[$];
    wexp_t       wq[$];

    logic        prev_stall;
    logic [4:0]  prev_rd;
    logic [31:0] prev_data;

    vpu_cfg_dispatch_if #(.XLEN(32), .RD_BITS(5)) bus ();

    assign bus.VCFG_read_valid_i = bus.VCFG_valid_o & resp_en;
    assign bus.VCFG_read_data_i  = resp_data;

    vpu_cfg_dispatch #(.XLEN(32), .RD_BITS(5)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input CFG_CSR_OP_e op, input logic [31:0] xv,
                        input logic [4:0] rd, input logic we);
        VPU_uOP_t u;
        u                  = '0;
        u.mode.cfg.csr_op  = op;
        u.rs1.xval         = xv;
        u.vtype            = 8'h5a;
        bus.uop_i          = u;
        bus.uop_rd_i       = rd;
        bus.uop_rd_we_i    = we;
        bus.uop_valid_i    = 1'b1;
        @(posedge clk);
        #1 bus.uop_valid_i = 1'b0;
    endtask

    // CSR strobe monitor
    always @(negedge clk) begin
        if (rst_ni && bus.VCFG_valid_o) begin
            if (vq.size() == 0) begin
                chk("vcfg_unexpected_strobe", 64'(1), 64'(0));
            end else begin
                vexp_t e;
                e = vq.pop_front();
                chk("vcfg_entry_op", 64'(bus.VCFG_entry_o.mode.cfg.csr_op), 64'(e.op));
                chk("vcfg_entry_xval", 64'(bus.VCFG_entry_o.rs1.xval), 64'(e.xv));
            end
        end
    end

    // Writeback monitor: handshake scoreboard plus hold-stable checks
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("wb_valid_held", 64'(bus.wb_valid_o), 64'(1));
                chk("wb_rd_held", 64'(bus.wb_rd_o), 64'(prev_rd));
                chk("wb_data_held", 64'(bus.wb_data_o), 64'(prev_data));
            end
            if (bus.wb_valid_o && bus.wb_ready_i) begin
                if (wq.size() == 0) begin
                    chk("wb_unexpected", 64'(1), 64'(0));
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wb_rd", 64'(bus.wb_rd_o), 64'(e.rd));
                    chk("wb_data", 64'(bus.wb_data_o), 64'(e.data));
                end
            end
            prev_stall = bus.wb_valid_o && !bus.wb_ready_i;
            prev_rd    = bus.wb_rd_o;
            prev_data  = bus.wb_data_o;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; prev_stall = 1'b0;
        rst_ni = 1'b0; resp_en = 1'b1; resp_data = '0;
        bus.uop_valid_i = 1'b0; bus.uop_i = '0; bus.uop_rd_i = '0;
        bus.uop_rd_we_i = 1'b0; bus.flush_i = 1'b0; bus.vec_inflight_i = 1'b0;
        bus.wb_ready_i = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_uop_ready", 64'(bus.uop_ready_o), 64'(0));
        chk("rst_vcfg_valid", 64'(bus.VCFG_valid_o), 64'(0));
        chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'(0));
        chk("rst_block", 64'(bus.vec_issue_block_o), 64'(0));
        chk("rst_entry", 64'(bus.VCFG_entry_o), 64'(0));
        @(posedge clk); #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.uop_ready_o), 64'(1));

        // VL read with pipeline busy: no drain, minimum latency
        bus.vec_inflight_i = 1'b1; resp_data = 32'h10;
        vq.push_back('{op: CFG_VL_READ, xv: 32'h0});
        wq.push_back('{rd: 5'd3, data: 32'h10});
        send(CFG_VL_READ, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        chk("t1_strobe_n1", 64'(bus.VCFG_valid_o), 64'(1));
        chk("t1_block_n1", 64'(bus.vec_issue_block_o), 64'(0));
        @(negedge clk);
        chk("t1_wb_valid_n2", 64'(bus.wb_valid_o), 64'(1));
        chk("t1_block_n2", 64'(bus.vec_issue_block_o), 64'(0));
        @(negedge clk);
        chk("t1_ready_n3", 64'(bus.uop_ready_o), 64'(1));
        chk("t1_wb_done_n3", 64'(bus.wb_valid_o), 64'(0));

        // VSETVL waits out 5 busy cycles
        resp_data = 32'h8;
        vq.push_back('{op: CFG_VSETVL, xv: 32'h20});
        wq.push_back('{rd: 5'd5, data: 32'h8});
        send(CFG_VSETVL, 32'h20, 5'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_drain_block", 64'(bus.vec_issue_block_o), 64'(1));
            chk("t2_drain_nostrobe", 64'(bus.VCFG_valid_o), 64'(0));
        end
        bus.vec_inflight_i = 1'b0;
        @(negedge clk);
        chk("t2_strobe", 64'(bus.VCFG_valid_o), 64'(1));
        chk("t2_block_issue", 64'(bus.vec_issue_block_o), 64'(1));
        @(negedge clk);
        chk("t2_wb_valid", 64'(bus.wb_valid_o), 64'(1));
        chk("t2_block_wb", 64'(bus.vec_issue_block_o), 64'(0));
        @(negedge clk);

        // VXRM write without rd: no writeback, ready again at N+2
        vq.push_back('{op: CFG_VXRM_WRITE, xv: 32'h2});
        send(CFG_VXRM_WRITE, 32'h2, 5'd1, 1'b0);
        @(negedge clk);
        chk("t3_strobe", 64'(bus.VCFG_valid_o), 64'(1));
        chk("t3_ready_busy", 64'(bus.uop_ready_o), 64'(0));
        @(negedge clk);
        chk("t3_ready_n2", 64'(bus.uop_ready_o), 64'(1));
        chk("t3_no_wb", 64'(bus.wb_valid_o), 64'(0));

        // Writeback back-pressure
        bus.wb_ready_i = 1'b0; resp_data = 32'hdeadbeef;
        vq.push_back('{op: CFG_VL_READ, xv: 32'h1});
        wq.push_back('{rd: 5'd7, data: 32'hdeadbeef});
        send(CFG_VL_READ, 32'h1, 5'd7, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", 64'(bus.wb_valid_o), 64'(1));
            chk("t4_stall_ready", 64'(bus.uop_ready_o), 64'(0));
        end
        @(posedge clk); #1 bus.wb_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_idle_after", 64'(bus.uop_ready_o), 64'(1));

        // Flush while draining: no strobe, back to IDLE
        bus.vec_inflight_i = 1'b1;
        send(CFG_VSETVLI, 32'h40, 5'd9, 1'b1);
        @(negedge clk);
        chk("t5_block_drain", 64'(bus.vec_issue_block_o), 64'(1));
        bus.flush_i = 1'b1;
        @(posedge clk); #1 bus.flush_i = 1'b0;
        @(negedge clk);
        chk("t5_ready", 64'(bus.uop_ready_o), 64'(1));
        chk("t5_block_drop", 64'(bus.vec_issue_block_o), 64'(0));
        bus.vec_inflight_i = 1'b0;
        @(negedge clk); @(negedge clk);

        // Flush in WB is ignored
        bus.wb_ready_i = 1'b0; resp_data = 32'h55;
        vq.push_back('{op: CFG_VTYPE_READ, xv: 32'h3});
        wq.push_back('{rd: 5'd11, data: 32'h55});
        send(CFG_VTYPE_READ, 32'h3, 5'd11, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_wb_valid", 64'(bus.wb_valid_o), 64'(1));
        #1 bus.flush_i = 1'b1;
        @(negedge clk);
        chk("t6_wb_survives_flush", 64'(bus.wb_valid_o), 64'(1));
        @(posedge clk); #1 bus.wb_ready_i = 1'b1;
        @(posedge clk); #1 bus.flush_i = 1'b0;
        @(negedge clk);
        chk("t6_idle", 64'(bus.uop_ready_o), 64'(1));

        // Flush in IDLE drops the offered uop
        bus.flush_i = 1'b1;
        send(CFG_VL_READ, 32'h4, 5'd12, 1'b1);
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("t7_dropped_nostrobe", 64'(bus.VCFG_valid_o), 64'(0));
        chk("t7_still_ready", 64'(bus.uop_ready_o), 64'(1));

        // No read response: zero captured
        resp_en = 1'b0; resp_data = 32'hab;
        vq.push_back('{op: CFG_VLENB_READ, xv: 32'h5});
        wq.push_back('{rd: 5'd2, data: 32'h0});
        send(CFG_VLENB_READ, 32'h5, 5'd2, 1'b1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        resp_en = 1'b1;

        // Asynchronous reset mid-WB
        bus.wb_ready_i = 1'b0; resp_data = 32'h77;
        vq.push_back('{op: CFG_VL_READ, xv: 32'h6});
        send(CFG_VL_READ, 32'h6, 5'd4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t9_wb_before_rst", 64'(bus.wb_valid_o), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk("t9_rst_wb_valid", 64'(bus.wb_valid_o), 64'(0));
        chk("t9_rst_vcfg_valid", 64'(bus.VCFG_valid_o), 64'(0));
        chk("t9_rst_wb_data", 64'(bus.wb_data_o), 64'(0));
        bus.wb_ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("t9_idle_after_rst", 64'(bus.uop_ready_o), 64'(1));
        chk("t9_wb_low_after_rst", 64'(bus.wb_valid_o), 64'(0));

        @(negedge clk);
        chk("vcfg_queue_drained", 64'(vq.size()), 64'(0));
        chk("wb_queue_drained", 64'(wq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vpu_cfg_dispatch.md
Name: vpu_cfg_dispatch

Overview:
- Initiator side of the vector-config channel. Accepts config/CSR micro-ops from VPU ISSUE, serialises them and holds them until the vector pipeline drains where ordering requires it.
- Presents each op for exactly one cycle on the VCFG_valid/VCFG_entry interface of the CSR unit, and captures the same-cycle VCFG_read response.
- Returns that response to scalar COMMIT through a valid/ready writeback handshake.
- Blocks further vector issue while a CSR-modifying op is pending.

Parameters:
- XLEN, 32, width of scalar rs1 value and writeback data.
- RD_BITS, 5, scalar destination register index width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- uop_valid_i  in  1  config uop offered by ISSUE
- uop_ready_o  out  1  block can accept a uop
- uop_i  in  VPU_uOP_t  config uop (mode.cfg.csr_op, vtype, keep_vl, vlmax, rs1.xval)
- uop_rd_i  in  RD_BITS  scalar destination index
- uop_rd_we_i  in  1  uop writes a scalar rd
- flush_i  in  1  kill any held, not-yet-issued uop
- vec_inflight_i  in  1  vector execution pipeline non-empty
- vec_issue_block_o  out  1  ISSUE must not dispatch new vector ops
- VCFG_valid_o  out  1  one-cycle strobe to CSR unit
- VCFG_entry_o  out  VPU_uOP_t  held uop
- VCFG_read_valid_i  in  1  CSR unit response valid (same cycle as strobe)
- VCFG_read_data_i  in  XLEN  CSR read / new vl value
- wb_valid_o  out  1  writeback to COMMIT
- wb_ready_i  in  1  COMMIT accepts writeback
- wb_rd_o  out  RD_BITS  destination index
- wb_data_o  out  XLEN  destination data

Behaviour:
- Reset is asynchronous. All outputs are 0 and the FSM is IDLE. Held uop, rd and data registers are cleared.
- FSM states: IDLE, DRAIN, ISSUE, WB.
- uop_ready_o = (state == IDLE). A uop transfers when uop_valid_i && uop_ready_o; uop, rd and rd_we are registered on transfer.
- needs_drain is computed from csr_op: 1 for every op except CFG_VLENB_READ, CFG_VTYPE_READ and CFG_VL_READ.
- Transition out of IDLE on transfer:
  - to DRAIN if needs_drain && vec_inflight_i;
  - otherwise to ISSUE.
- DRAIN: wait until vec_inflight_i == 0, then go to ISSUE on the next edge.
- ISSUE lasts one cycle. VCFG_valid_o = 1 and VCFG_entry_o = held uop.
  - If VCFG_read_valid_i, capture VCFG_read_data_i into the data register.
  - If VCFG_read_valid_i is low, capture 0.
  - Then go to WB if rd_we, else to IDLE.
- VCFG_entry_o shows the held uop in every state. VCFG_valid_o is asserted only in ISSUE.
- WB: wb_valid_o = 1, with wb_rd_o and wb_data_o stable.
  - On wb_ready_i go to IDLE.
  - wb_valid_o never drops without a handshake.
- vec_issue_block_o = 1 from the cycle after transfer of a needs_drain uop until the ISSUE cycle inclusive. This prevents a drain livelock. It is 0 in WB.
- Minimum latency with no drain and wb_ready_i high: transfer at cycle N, ISSUE at N+1, wb_valid_o at N+2, IDLE at N+3.
- Back-to-back: a new uop is accepted only in IDLE. Throughput is at most one op per 2 cycles without rd and per 3 cycles with rd.
- flush_i:
  - In DRAIN: return to IDLE with no CSR strobe.
  - In ISSUE and WB: ignored, because the CSR state is already committed.
  - In IDLE: the simultaneous transfer is dropped (uop_ready_o stays 1, but no uop is taken).
- Writeback data is passed through unmodified (XLEN bits). No arithmetic is done in this block.

Optional Feature:
- Macro: VPU_CFG_DISPATCH_BYPASS_EN.
- When defined: ops with needs_drain == 0 and rd_we == 1 skip the registered path. In IDLE with uop_valid_i, VCFG_valid_o is asserted combinationally for that same cycle, data is captured, and the FSM goes directly to WB (latency N to N+1). DRAIN ops are unchanged.
- When undefined: all ops take the registered IDLE→ISSUE path.

Decomposition:
- Add to the shared VPU package:
  - the CFG_DISP_STATE_e enum (IDLE, DRAIN, ISSUE, WB);
  - a function cfg_needs_drain(csr_op), so ISSUE can reuse it.
- VPU_uOP_t and the CSR op enum are already in the package.
- No sub-module. A single always_ff/always_comb FSM is sufficient.

Test Plan:
- CFG_VL_READ with rd_we=1, vec_inflight_i=1, CSR returns 0x10 → no DRAIN, VCFG_valid_o at N+1, wb_valid_o at N+2 with wb_data_o=0x10, vec_issue_block_o stays 0.
- CFG_VSETVL with rd_we=1, vec_inflight_i high for 5 cycles → DRAIN for 5 cycles, vec_issue_block_o high throughout, single VCFG_valid_o pulse after drain, wb_data_o = returned vl (e.g. 0x8).
- CFG_VXRM_WRITE with rd_we=0 → after ISSUE returns to IDLE, wb_valid_o never asserted, uop_ready_o high again at N+2.
- WB with wb_ready_i low for 3 cycles → wb_valid_o, wb_rd_o and wb_data_o held stable, uop_ready_o=0, IDLE the cycle after wb_ready_i=1.
- flush_i in DRAIN → no VCFG_valid_o pulse, IDLE next cycle, vec_issue_block_o drops; flush_i in WB → wb still completes.
- rst_ni asserted low mid-WB (asynchronous, off-edge) → wb_valid_o and VCFG_valid_o go to 0 immediately, state IDLE after release.
